// File: rtl/ysyx_mem_arbiter_if.sv
// rtl/ysyx_mem_arbiter_if.sv - IFU/EXU request, response and memory-port bundle for ysyx_mem_arbiter
`ifndef YSYX_W_WIDTH
`define YSYX_W_WIDTH 32
`endif

interface ysyx_mem_arbiter_if #(
  parameter int BIT_W = `YSYX_W_WIDTH
);
  // IFU fetch requester
  logic               ifu_avalid;
  logic [BIT_W-1:0]   ifu_addr;
  logic               ifu_rvalid_o;
  logic [BIT_W-1:0]   ifu_rdata_o;

  // EXU load/store requester
  logic               exu_avalid;
  logic               exu_wen;
  logic [BIT_W-1:0]   exu_addr;
  logic [BIT_W-1:0]   exu_wdata;
  logic [BIT_W/8-1:0] exu_wstrb;
  logic               exu_rvalid_o;
  logic               exu_wready_o;
  logic [BIT_W-1:0]   exu_rdata_o;

  // shared data-memory port
  logic               mem_avalid_o;
  logic               mem_aready;
  logic               mem_wen_o;
  logic [BIT_W-1:0]   mem_addr_o;
  logic [BIT_W-1:0]   mem_wdata_o;
  logic [BIT_W/8-1:0] mem_wstrb_o;
  logic               mem_rvalid;
  logic [BIT_W-1:0]   mem_rdata;
  logic               mem_bvalid;

  // sticky watchdog flag
  logic               err_o;

  // arbiter side: serves the requesters and masters the memory port
  modport slave (
    input  ifu_avalid, ifu_addr,
    input  exu_avalid, exu_wen, exu_addr, exu_wdata, exu_wstrb,
    input  mem_aready, mem_rvalid, mem_rdata, mem_bvalid,
    output ifu_rvalid_o, ifu_rdata_o,
    output exu_rvalid_o, exu_wready_o, exu_rdata_o,
    output mem_avalid_o, mem_wen_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output err_o
  );

  // environment side: requesters plus the memory model
  modport master (
    output ifu_avalid, ifu_addr,
    output exu_avalid, exu_wen, exu_addr, exu_wdata, exu_wstrb,
    output mem_aready, mem_rvalid, mem_rdata, mem_bvalid,
    input  ifu_rvalid_o, ifu_rdata_o,
    input  exu_rvalid_o, exu_wready_o, exu_rdata_o,
    input  mem_avalid_o, mem_wen_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  err_o
  );
endinterface

// File: rtl/ysyx_mem_arbiter.sv
// rtl/ysyx_mem_arbiter.sv - IFU/EXU arbiter and sequencer for the shared data-memory port
module ysyx_mem_arbiter #(
  parameter int BIT_W        = `YSYX_W_WIDTH,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 1024
) (
  input  logic              clk,
  input  logic              rst,
  ysyx_mem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WD_LAST    = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit            WD_ON      = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t             state;
  logic               owner_ifu;
  logic [SW-1:0]      streak;
  logic [WW-1:0]      wd;

  logic               mem_avalid_q;
  logic               mem_wen_q;
  logic [BIT_W-1:0]   mem_addr_q;
  logic [BIT_W-1:0]   mem_wdata_q;
  logic [BIT_W/8-1:0] mem_wstrb_q;

  logic               ifu_rvalid_q;
  logic               exu_rvalid_q;
  logic               exu_wready_q;
  logic [BIT_W-1:0]   ifu_rdata_q;
  logic [BIT_W-1:0]   exu_rdata_q;
  logic               err_q;

  logic               ifu_elig;
  logic               exu_elig;
  logic               pick_ifu;
  logic               resp_match;
  logic               done;
  logic               abort;
  logic [BIT_W-1:0]   resp_data;

  // Grant choice and completion/abort decisions for the current cycle
  always_comb begin
    // a requester whose response is on the wire right now still holds avalid; do not serve it twice
    ifu_elig   = bus.ifu_avalid & ~ifu_rvalid_q;
    exu_elig   = bus.exu_avalid & ~(exu_rvalid_q | exu_wready_q);
    pick_ifu   = ifu_elig & (~exu_elig | (streak == STREAK_MAX));
    // IFU transactions latch wen=0, so the latched wen alone selects the expected response
    resp_match = mem_wen_q ? bus.mem_bvalid : bus.mem_rvalid;
    done       = ((state == ADDR) & bus.mem_aready & resp_match) | ((state == DATA) & resp_match);
    abort      = WD_ON & ~done & (state != IDLE) & (wd == WD_LAST);
    resp_data  = abort ? '0 : bus.mem_rdata;
  end

  // Transaction FSM: grant in IDLE, request in ADDR, wait in DATA, registered one-cycle response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      owner_ifu    <= 1'b0;
      streak       <= '0;
      wd           <= '0;
      mem_avalid_q <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      ifu_rvalid_q <= 1'b0;
      exu_rvalid_q <= 1'b0;
      exu_wready_q <= 1'b0;
      ifu_rdata_q  <= '0;
      exu_rdata_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      ifu_rvalid_q <= 1'b0;
      exu_rvalid_q <= 1'b0;
      exu_wready_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!bus.ifu_avalid) begin
            streak <= '0;
          end
          if (ifu_elig | exu_elig) begin
            state        <= ADDR;
            mem_avalid_q <= 1'b1;
            wd           <= '0;
            owner_ifu    <= pick_ifu;
            if (pick_ifu) begin
              mem_wen_q   <= 1'b0;
              mem_addr_q  <= bus.ifu_addr;
              mem_wdata_q <= '0;
              mem_wstrb_q <= '0;
              streak      <= '0;
            end else begin
              mem_wen_q   <= bus.exu_wen;
              mem_addr_q  <= bus.exu_addr;
              mem_wdata_q <= bus.exu_wdata;
              mem_wstrb_q <= bus.exu_wstrb;
              // only counts while IFU is actually waiting; saturates at the limit
              if (bus.ifu_avalid && (streak != STREAK_MAX)) begin
                streak <= streak + 1'b1;
              end
            end
          end
        end
        ADDR, DATA: begin
          if (done | abort) begin
            state        <= IDLE;
            mem_avalid_q <= 1'b0;
            if (owner_ifu) begin
              ifu_rvalid_q <= 1'b1;
              ifu_rdata_q  <= resp_data;
            end else if (mem_wen_q) begin
              exu_wready_q <= 1'b1;
            end else begin
              exu_rvalid_q <= 1'b1;
              exu_rdata_q  <= resp_data;
            end
            if (abort) begin
              err_q <= 1'b1;
            end
          end else begin
            wd <= wd + 1'b1;
            if ((state == ADDR) && bus.mem_aready) begin
              state        <= DATA;
              mem_avalid_q <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_avalid_o = mem_avalid_q;
  assign bus.mem_wen_o    = mem_wen_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_wdata_o  = mem_wdata_q;
  assign bus.mem_wstrb_o  = mem_wstrb_q;
  assign bus.ifu_rvalid_o = ifu_rvalid_q;
  assign bus.ifu_rdata_o  = ifu_rdata_q;
  assign bus.exu_rvalid_o = exu_rvalid_q;
  assign bus.exu_wready_o = exu_wready_q;
  assign bus.exu_rdata_o  = exu_rdata_q;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_ysyx_mem_arbiter.sv
// tb/tb_ysyx_mem_arbiter.sv - randomized transaction-level bench for ysyx_mem_arbiter
module tb_ysyx_mem_arbiter;
  localparam int W     = 32;
  localparam int LIMIT = 4;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic rst;

  ysyx_mem_arbiter_if #(.BIT_W(W)) bus ();

  ysyx_mem_arbiter #(.BIT_W(W), .STARVE_LIMIT(LIMIT), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference state: arbitration streak, who is holding avalid through its pulse, sticky error
  int           streak;
  bit           pulse_ifu;
  bit           pulse_exu;
  bit           exp_err;
  logic [W-1:0] last_ifu_rdata;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_mem();
    bus.mem_aready = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_bvalid = 1'b0;
  endtask

  task automatic model_reset();
    streak = 0; pulse_ifu = 0; pulse_exu = 0; exp_err = 0; last_ifu_rdata = '0;
  endtask

  // the requester that just saw its response drops avalid one cycle later
  task automatic release_pulsed();
    if (pulse_ifu) bus.ifu_avalid = 1'b0;
    if (pulse_exu) bus.exu_avalid = 1'b0;
    pulse_ifu = 0;
    pulse_exu = 0;
  endtask

  task automatic check_payload(input string tag, input logic [W-1:0] ea, input bit wr,
                               input logic [W-1:0] ed, input logic [3:0] es);
    check({tag, "_avalid"}, bus.mem_avalid_o, 1'b1);
    check({tag, "_addr"}, bus.mem_addr_o, ea);
    check({tag, "_wen"}, bus.mem_wen_o, wr);
    check({tag, "_wstrb"}, bus.mem_wstrb_o, es);
    if (wr) check({tag, "_wdata"}, bus.mem_wdata_o, ed);
  endtask

  // one arbitration decision from the current IDLE cycle; da/dr = aready delay / response delay after aready
  task automatic run_txn(input int da, input int dr, input bit to);
    bit           ie, ee, wi, wr;
    logic [W-1:0] ea, ed, rd;
    logic [3:0]   es;
    ie = bus.ifu_avalid && !pulse_ifu;
    ee = bus.exu_avalid && !pulse_exu;
    // memory chatter while idle or granting must never produce a response
    bus.mem_aready = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_bvalid = 1'b1;
    bus.mem_rdata  = 32'hdead_beef;
    if (!ie && !ee) begin
      if (!bus.ifu_avalid) streak = 0;
      step();
      clear_mem();
      release_pulsed();
      check("idle_avalid", bus.mem_avalid_o, 1'b0);
      check("idle_pulse", {bus.ifu_rvalid_o, bus.exu_rvalid_o, bus.exu_wready_o}, 3'b000);
      return;
    end
    wi = ie && (!ee || streak == LIMIT);
    if (wi) streak = 0;
    else if (bus.ifu_avalid) streak = (streak < LIMIT) ? streak + 1 : LIMIT;
    else streak = 0;
    wr = !wi && bus.exu_wen;
    ea = wi ? bus.ifu_addr : bus.exu_addr;
    ed = bus.exu_wdata;
    es = wi ? 4'h0 : bus.exu_wstrb;
    step();
    clear_mem();
    release_pulsed();
    check("pulse_one_cycle", {bus.ifu_rvalid_o, bus.exu_rvalid_o, bus.exu_wready_o}, 3'b000);
    check_payload("grant", ea, wr, ed, es);
    check("ifu_rdata_hold", bus.ifu_rdata_o, last_ifu_rdata);
    check("err_before", bus.err_o, exp_err);
    // live requester inputs wander after grant; only the latched copy may reach memory
    if (wi) bus.ifu_addr = $urandom;
    else begin
      bus.exu_addr = $urandom; bus.exu_wdata = $urandom;
      bus.exu_wstrb = 4'($urandom); bus.exu_wen = 1'($urandom);
    end
    if (to) begin
      for (int k = 0; k < TMO - 1; k++) begin
        bus.mem_rvalid = 1'($urandom); bus.mem_bvalid = 1'($urandom);
        step();
        check("to_avalid_held", bus.mem_avalid_o, 1'b1);
        check("to_no_err_yet", bus.err_o, exp_err);
      end
      clear_mem();
      step();
      exp_err = 1;
      rd = '0;
    end else begin
      for (int k = 0; k < da; k++) begin
        bus.mem_rvalid = 1'($urandom); bus.mem_bvalid = 1'($urandom); bus.mem_rdata = $urandom;
        step();
        check_payload("addr_hold", ea, wr, ed, es);
      end
      clear_mem();
      bus.mem_aready = 1'b1;
      rd = $urandom;
      bus.mem_rdata = rd;
      if (dr == 0) begin
        if (wr) bus.mem_bvalid = 1'b1; else bus.mem_rvalid = 1'b1;
      end else begin
        if (wr) bus.mem_rvalid = 1'($urandom); else bus.mem_bvalid = 1'($urandom);
      end
      step();
      clear_mem();
      if (dr > 0) begin
        check("data_avalid_low", bus.mem_avalid_o, 1'b0);
        for (int k = 0; k < dr - 1; k++) begin
          if (wr) bus.mem_rvalid = 1'($urandom); else bus.mem_bvalid = 1'($urandom);
          bus.mem_rdata = $urandom;
          step();
          clear_mem();
          check("data_wait_pulse", {bus.ifu_rvalid_o, bus.exu_rvalid_o, bus.exu_wready_o}, 3'b000);
        end
        if (wr) bus.mem_bvalid = 1'b1; else bus.mem_rvalid = 1'b1;
        bus.mem_rdata = rd;
        step();
        clear_mem();
      end
    end
    check("resp_avalid_low", bus.mem_avalid_o, 1'b0);
    check("resp_err", bus.err_o, exp_err);
    check("resp_ifu_rvalid", bus.ifu_rvalid_o, wi);
    check("resp_exu_rvalid", bus.exu_rvalid_o, !wi && !wr);
    check("resp_exu_wready", bus.exu_wready_o, wr);
    if (wi) begin
      check("resp_ifu_rdata", bus.ifu_rdata_o, rd);
      last_ifu_rdata = rd;
      pulse_ifu = 1;
    end else begin
      if (!wr) check("resp_exu_rdata", bus.exu_rdata_o, rd);
      pulse_exu = 1;
    end
  endtask

  task automatic raise_random();
    if (!bus.ifu_avalid && $urandom_range(0, 2) != 0) begin
      bus.ifu_avalid = 1'b1;
      bus.ifu_addr   = $urandom & 32'hffff_fffc;
    end
    if (!bus.exu_avalid && $urandom_range(0, 2) != 0) begin
      bus.exu_avalid = 1'b1;
      bus.exu_wen    = 1'($urandom);
      bus.exu_addr   = $urandom;
      bus.exu_wdata  = $urandom;
      bus.exu_wstrb  = 4'($urandom);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.ifu_avalid = 0; bus.ifu_addr = '0;
    bus.exu_avalid = 0; bus.exu_wen = 0; bus.exu_addr = '0; bus.exu_wdata = '0; bus.exu_wstrb = '0;
    bus.mem_rdata = '0;
    clear_mem();
    model_reset();
    step();
    step();
    check("rst_avalid", bus.mem_avalid_o, 1'b0);
    check("rst_pulses", {bus.ifu_rvalid_o, bus.exu_rvalid_o, bus.exu_wready_o}, 3'b000);
    check("rst_payload", {bus.mem_addr_o ^ bus.mem_wdata_o, bus.mem_wen_o, bus.mem_wstrb_o} == '0, 1'b1);
    check("rst_rdata", bus.ifu_rdata_o | bus.exu_rdata_o, '0);
    check("rst_err", bus.err_o, 1'b0);
    rst = 1'b1;
    step();

    // asynchronous reset while the address phase is pending
    bus.ifu_avalid = 1'b1;
    bus.ifu_addr   = 32'h8000_0040;
    step();
    check("midrst_avalid_before", bus.mem_avalid_o, 1'b1);
    #2 rst = 1'b0;
    #1 check("midrst_avalid_drop", bus.mem_avalid_o, 1'b0);
    bus.ifu_avalid = 1'b0;
    bus.mem_aready = 1'b1; bus.mem_rvalid = 1'b1;
    step();
    check("midrst_no_pulse", {bus.ifu_rvalid_o, bus.exu_rvalid_o, bus.exu_wready_o}, 3'b000);
    check("midrst_err", bus.err_o, 1'b0);
    clear_mem();
    rst = 1'b1;
    model_reset();
    step();
    check("postrst_no_pulse", {bus.ifu_rvalid_o, bus.exu_rvalid_o, bus.exu_wready_o}, 3'b000);

    // IFU alone: aready in cycle 1, rvalid in cycle 3, pulse in cycle 4
    bus.ifu_avalid = 1'b1;
    bus.ifu_addr   = 32'h8000_0000;
    run_txn(0, 2, 0);
    run_txn(0, 0, 0);

    // simultaneous requests: EXU store first, IFU next
    bus.ifu_avalid = 1'b1; bus.ifu_addr = 32'h8000_0004;
    bus.exu_avalid = 1'b1; bus.exu_wen = 1'b1; bus.exu_addr = 32'h8000_0100;
    bus.exu_wdata  = 32'h1234_5678; bus.exu_wstrb = 4'hf;
    run_txn(1, 1, 0);
    run_txn(0, 0, 0);

    // both held continuously
    for (int i = 0; i < 6; i++) begin
      if (!bus.ifu_avalid) begin bus.ifu_avalid = 1'b1; bus.ifu_addr = 32'h8000_1000 + 32'(i * 4); end
      if (!bus.exu_avalid) begin
        bus.exu_avalid = 1'b1; bus.exu_wen = 1'b0; bus.exu_addr = 32'h9000_0000 + 32'(i * 8);
        bus.exu_wstrb = 4'h3;
      end
      run_txn(0, 0, 0);
    end

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      raise_random();
      run_txn($urandom_range(0, 3), $urandom_range(0, 3), 0);
    end
    for (int i = 0; i < 4; i++) run_txn(0, 0, 0);

    // watchdog: memory never answers, then late chatter while idle
    bus.ifu_avalid = 1'b1;
    bus.ifu_addr   = 32'h8000_2000;
    run_txn(0, 0, 1);
    run_txn(0, 0, 0);
    run_txn(0, 0, 0);
    bus.exu_avalid = 1'b1; bus.exu_wen = 1'b1; bus.exu_addr = 32'h8000_3000;
    bus.exu_wdata = 32'hcafe_f00d; bus.exu_wstrb = 4'h1;
    run_txn(2, 1, 0);
    run_txn(0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
